wb_reg_retry: RTL and testbench
===============================

WB_REG_RETRY -- requirements
Module: wb_reg_retry

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8, 16, 32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 SHALL have parameter TIMEOUT, default 255, cycles a slave may stall before error; 0 disables the timeout.
REQ-005 SHALL have parameter MAX_RETRY, default 3, number of slave-RTY reissues before RTY is passed to the master.
REQ-006 SHALL have ports, in order: clk input 1, single clock; rst_n input 1, reset, synchronous active-low.
REQ-007 SHALL have master-side ports: wbm_adr_i in ADDR_WIDTH; wbm_dat_i in DATA_WIDTH; wbm_dat_o out DATA_WIDTH; wbm_we_i in 1; wbm_sel_i in SELECT_WIDTH; wbm_stb_i in 1; wbm_ack_o out 1; wbm_err_o out 1; wbm_rty_o out 1; wbm_cyc_i in 1.
REQ-008 SHALL have slave-side ports: wbs_adr_o out ADDR_WIDTH; wbs_dat_i in DATA_WIDTH; wbs_dat_o out DATA_WIDTH; wbs_we_o out 1; wbs_sel_o out SELECT_WIDTH; wbs_stb_o out 1; wbs_ack_i in 1; wbs_err_i in 1; wbs_rty_i in 1; wbs_cyc_o out 1.
REQ-009 SHALL have timeout_o out 1, single-cycle pulse when a transfer is terminated by timeout.

Function
REQ-010 SHALL implement states IDLE, ISSUE, BACKOFF, RESP; all outputs registered.
REQ-011 IDLE: on wbm_cyc_i & wbm_stb_i, SHALL capture adr/dat/we/sel, clear retry and timeout counters, assert wbs_cyc_o/wbs_stb_o next cycle (request latency 1), go to ISSUE.
REQ-012 wbs_cyc_o SHALL follow registered wbm_cyc_i whenever the master holds CYC, including between transfers (bus lock).
REQ-013 ISSUE: slave response SHALL be decoded with priority ack > err > rty when several inputs are asserted together.
REQ-014 ISSUE, ack: SHALL register wbs_dat_i into wbm_dat_o, pulse wbm_ack_o next cycle (response latency 1), drop wbs_stb_o/wbs_we_o, go to RESP.
REQ-015 ISSUE, err: SHALL pulse wbm_err_o next cycle, wbm_dat_o = 0, go to RESP.
REQ-016 ISSUE, rty with retry count < MAX_RETRY: SHALL increment count, drop wbs_stb_o for exactly one cycle (BACKOFF), then reassert with identical captured fields.
REQ-017 ISSUE, rty with retry count = MAX_RETRY: SHALL pulse wbm_rty_o next cycle, go to RESP; MAX_RETRY = 0 passes the first RTY straight through.
REQ-018 Timeout counter SHALL count ISSUE cycles without response and restart at each reissue; on reaching TIMEOUT it SHALL drop wbs_stb_o and wbs_cyc_o, pulse wbm_err_o and timeout_o together, and go to RESP.
REQ-019 A slave response in the same cycle the counter reaches TIMEOUT SHALL win; no timeout_o.
REQ-020 RESP: response outputs SHALL be high exactly one cycle; the still-asserted master STB SHALL NOT be recaptured; next state IDLE, earliest new capture one cycle later.
REQ-021 wbm_cyc_i low in ISSUE or BACKOFF SHALL abort: wbs_cyc_o/wbs_stb_o low next cycle, no master response, return to IDLE.
REQ-022 Retry counter width SHALL be $clog2(MAX_RETRY+1), minimum 1; timeout counter width $clog2(TIMEOUT+1), minimum 1; counters SHALL saturate, never wrap.

Reset
REQ-023 While rst_n is low at a clk edge, all outputs and captured registers SHALL be 0, counters 0, state IDLE, regardless of state (abort mid-transfer with no response).
REQ-024 The first capture SHALL be possible in the first cycle with rst_n high.

Structure
REQ-025 State encoding and the response-code enumeration (NONE, ACK, ERR, RTY) SHALL live in shared package wb_pkg.
REQ-026 The saturating timeout/retry counter SHALL be one sub-module, wb_sat_counter, instantiated twice.

Verification
REQ-027 Write adr 0x100 dat 0xDEADBEEF sel 0xF, slave acks 2 cycles after wbs_stb_o -> wbs fields match, wbm_ack_o one-cycle pulse 1 cycle after wbs_ack_i.
REQ-028 Read, slave rty twice then ack dat 0x12345678, MAX_RETRY=3 -> two 1-cycle wbs_stb_o gaps, wbm_dat_o=0x12345678 with ack.
REQ-029 Slave rty 4 times, MAX_RETRY=3 -> exactly 4 wbs_stb_o assertions, wbm_rty_o pulse, no ack.
REQ-030 TIMEOUT=8, slave silent -> wbs_stb_o drops after 8 cycles, wbm_err_o and timeout_o pulse together; ack on cycle 8 instead -> ack, no timeout_o.
REQ-031 Master drops wbm_cyc_i during ISSUE, and separately rst_n low during BACKOFF -> wbs_cyc_o low next cycle, no master response, next request accepted normally.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the retrying Wishbone register slice.
// FSM states, slave response codes and small helpers.
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      BACKOFF = 2'd2,
      RESP    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      ACK  = 2'd1,
      ERR  = 2'd2,
      RTY  = 2'd3
   } resp_e;

   // Width needed to hold 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Simultaneous slave terminations resolve as ack > err > rty.
   function automatic resp_e decode_resp(
      input logic ack,
      input logic err,
      input logic rty
   );
      resp_e r;
      r = NONE;
      if (ack) begin
         r = ACK;
      end else if (err) begin
         r = ERR;
      end else if (rty) begin
         r = RTY;
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_sat_counter.sv
// wb_sat_counter: clearable up-counter that holds at MAX_VAL.
// Used for both the retry count and the stall timeout.
module wb_sat_counter #(
   parameter int MAX_VAL = 3,
   parameter int WIDTH   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Clear wins over increment; increment stops at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_reg_retry.sv
// wb_reg_retry: registered Wishbone master-to-slave slice.
// Reissues on slave RTY, times out silent slaves, aborts on CYC drop.
module wb_reg_retry
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 255,
   parameter int MAX_RETRY    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
   input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
   output logic [DATA_WIDTH-1:0]   wbm_dat_o,
   input  logic                    wbm_we_i,
   input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
   input  logic                    wbm_stb_i,
   output logic                    wbm_ack_o,
   output logic                    wbm_err_o,
   output logic                    wbm_rty_o,
   input  logic                    wbm_cyc_i,
   output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
   input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
   output logic [DATA_WIDTH-1:0]   wbs_dat_o,
   output logic                    wbs_we_o,
   output logic [SELECT_WIDTH-1:0] wbs_sel_o,
   output logic                    wbs_stb_o,
   input  logic                    wbs_ack_i,
   input  logic                    wbs_err_i,
   input  logic                    wbs_rty_i,
   output logic                    wbs_cyc_o,
   output logic                    timeout_o
);

   localparam int RW = cnt_width(MAX_RETRY);
   localparam int TW = cnt_width(TIMEOUT);

   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
   localparam logic [TW-1:0] TO_LAST =
      TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TO_EN = (TIMEOUT > 0);

   state_e state_q;
   state_e state_d;
   resp_e  resp;

   logic [RW-1:0] retry_cnt;
   logic [TW-1:0] to_cnt;
   logic          retry_ok;
   logic          to_hit;
   logic          retry_clr;
   logic          retry_inc;
   logic          to_clr;
   logic          to_inc;
   logic          req;

   logic                    wbs_cyc_q, wbs_cyc_d;
   logic                    wbs_stb_q, wbs_stb_d;
   logic                    wbs_we_q,  wbs_we_d;
   logic [ADDR_WIDTH-1:0]   wbs_adr_q, wbs_adr_d;
   logic [DATA_WIDTH-1:0]   wbs_dat_q, wbs_dat_d;
   logic [SELECT_WIDTH-1:0] wbs_sel_q, wbs_sel_d;
   logic [DATA_WIDTH-1:0]   wbm_dat_q, wbm_dat_d;
   logic                    wbm_ack_q, wbm_ack_d;
   logic                    wbm_err_q, wbm_err_d;
   logic                    wbm_rty_q, wbm_rty_d;
   logic                    timeout_q, timeout_d;

   assign req  = wbm_cyc_i && wbm_stb_i;
   assign resp = decode_resp(wbs_ack_i, wbs_err_i, wbs_rty_i);

   // Retries restart with each captured request.
   assign retry_clr = (state_q == IDLE);
   assign retry_inc = (state_q == ISSUE) && wbm_cyc_i
                      && (resp == RTY);
   assign retry_ok  = (retry_cnt < RETRY_LIM);

   // Stall time restarts on every (re)issue.
   assign to_clr = (state_q != ISSUE);
   assign to_inc = (state_q == ISSUE) && (resp == NONE);
   assign to_hit = TO_EN && (to_cnt == TO_LAST);

   wb_sat_counter #(
      .MAX_VAL (MAX_RETRY),
      .WIDTH   (RW)
   ) u_retry_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (retry_clr),
      .inc_i (retry_inc),
      .cnt_o (retry_cnt)
   );

   wb_sat_counter #(
      .MAX_VAL (TIMEOUT),
      .WIDTH   (TW)
   ) u_to_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (to_clr),
      .inc_i (to_inc),
      .cnt_o (to_cnt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: CYC drop aborts, responses beat the timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!wbm_cyc_i) begin
               state_d = IDLE;
            end else if (resp == RTY) begin
               state_d = retry_ok ? BACKOFF : RESP;
            end else if (resp != NONE) begin
               state_d = RESP;
            end else if (to_hit) begin
               state_d = RESP;
            end
         end
         BACKOFF: begin
            state_d = wbm_cyc_i ? ISSUE : IDLE;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output values for the next cycle; responses are one-cycle pulses.
   always_comb begin
      wbs_cyc_d = wbm_cyc_i;
      wbs_stb_d = 1'b0;
      wbs_we_d  = 1'b0;
      wbs_adr_d = wbs_adr_q;
      wbs_dat_d = wbs_dat_q;
      wbs_sel_d = wbs_sel_q;
      wbm_dat_d = wbm_dat_q;
      wbm_ack_d = 1'b0;
      wbm_err_d = 1'b0;
      wbm_rty_d = 1'b0;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               wbs_adr_d = wbm_adr_i;
               wbs_dat_d = wbm_dat_i;
               wbs_sel_d = wbm_sel_i;
               wbs_we_d  = wbm_we_i;
               wbs_stb_d = 1'b1;
            end
         end
         ISSUE: begin
            if (wbm_cyc_i) begin
               unique case (resp)
                  ACK: begin
                     wbm_ack_d = 1'b1;
                     wbm_dat_d = wbs_dat_i;
                  end
                  ERR: begin
                     wbm_err_d = 1'b1;
                     wbm_dat_d = '0;
                  end
                  RTY: begin
                     if (retry_ok) begin
                        wbs_we_d = wbs_we_q;
                     end else begin
                        wbm_rty_d = 1'b1;
                        wbm_dat_d = '0;
                     end
                  end
                  default: begin
                     if (to_hit) begin
                        wbs_cyc_d = 1'b0;
                        wbm_err_d = 1'b1;
                        timeout_d = 1'b1;
                        wbm_dat_d = '0;
                     end else begin
                        wbs_stb_d = 1'b1;
                        wbs_we_d  = wbs_we_q;
                     end
                  end
               endcase
            end
         end
         BACKOFF: begin
            if (wbm_cyc_i) begin
               wbs_stb_d = 1'b1;
               wbs_we_d  = wbs_we_q;
            end
         end
         RESP: begin
            wbs_stb_d = 1'b0;
         end
         default: begin
            wbs_stb_d = 1'b0;
         end
      endcase
   end

   // Output and capture registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wbs_cyc_q <= 1'b0;
         wbs_stb_q <= 1'b0;
         wbs_we_q  <= 1'b0;
         wbs_adr_q <= '0;
         wbs_dat_q <= '0;
         wbs_sel_q <= '0;
         wbm_dat_q <= '0;
         wbm_ack_q <= 1'b0;
         wbm_err_q <= 1'b0;
         wbm_rty_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         wbs_cyc_q <= wbs_cyc_d;
         wbs_stb_q <= wbs_stb_d;
         wbs_we_q  <= wbs_we_d;
         wbs_adr_q <= wbs_adr_d;
         wbs_dat_q <= wbs_dat_d;
         wbs_sel_q <= wbs_sel_d;
         wbm_dat_q <= wbm_dat_d;
         wbm_ack_q <= wbm_ack_d;
         wbm_err_q <= wbm_err_d;
         wbm_rty_q <= wbm_rty_d;
         timeout_q <= timeout_d;
      end
   end

   assign wbs_cyc_o = wbs_cyc_q;
   assign wbs_stb_o = wbs_stb_q;
   assign wbs_we_o  = wbs_we_q;
   assign wbs_adr_o = wbs_adr_q;
   assign wbs_dat_o = wbs_dat_q;
   assign wbs_sel_o = wbs_sel_q;
   assign wbm_dat_o = wbm_dat_q;
   assign wbm_ack_o = wbm_ack_q;
   assign wbm_err_o = wbm_err_q;
   assign wbm_rty_o = wbm_rty_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_reg_retry.sv
// tb_wb_reg_retry: directed table, hand sequences and random
// transactions for wb_reg_retry (TIMEOUT=8, MAX_RETRY=3).
module tb_wb_reg_retry;

   localparam int TO = 8;
   localparam int MR = 3;

   localparam int K_NONE = 0;
   localparam int K_ACK  = 1;
   localparam int K_ERR  = 2;
   localparam int K_RTY  = 3;

   localparam int O_NONE = 0;
   localparam int O_ACK  = 1;
   localparam int O_ERR  = 2;
   localparam int O_RTY  = 3;
   localparam int O_TO   = 4;

   typedef struct {
      logic            we;
      logic [31:0]     adr;
      logic [31:0]     dat;
      logic [3:0]      sel;
      logic [31:0]     sdat;
      logic [1:0]      pri;
      logic [5:0][1:0] kind;
      logic [5:0][3:0] dly;
      int              exp_oc;
      int              exp_natt;
      logic [31:0]     exp_rd;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wbm_adr_i = '0;
   logic [31:0] wbm_dat_i = '0;
   logic [31:0] wbm_dat_o;
   logic        wbm_we_i = 1'b0;
   logic [3:0]  wbm_sel_i = '0;
   logic        wbm_stb_i = 1'b0;
   logic        wbm_ack_o;
   logic        wbm_err_o;
   logic        wbm_rty_o;
   logic        wbm_cyc_i = 1'b0;
   logic [31:0] wbs_adr_o;
   logic [31:0] wbs_dat_i = '0;
   logic [31:0] wbs_dat_o;
   logic        wbs_we_o;
   logic [3:0]  wbs_sel_o;
   logic        wbs_stb_o;
   logic        wbs_ack_i = 1'b0;
   logic        wbs_err_i = 1'b0;
   logic        wbs_rty_i = 1'b0;
   logic        wbs_cyc_o;
   logic        timeout_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_reg_retry #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (32),
      .SELECT_WIDTH (4),
      .TIMEOUT      (TO),
      .MAX_RETRY    (MR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wbm_adr_i (wbm_adr_i),
      .wbm_dat_i (wbm_dat_i),
      .wbm_dat_o (wbm_dat_o),
      .wbm_we_i  (wbm_we_i),
      .wbm_sel_i (wbm_sel_i),
      .wbm_stb_i (wbm_stb_i),
      .wbm_ack_o (wbm_ack_o),
      .wbm_err_o (wbm_err_o),
      .wbm_rty_o (wbm_rty_o),
      .wbm_cyc_i (wbm_cyc_i),
      .wbs_adr_o (wbs_adr_o),
      .wbs_dat_i (wbs_dat_i),
      .wbs_dat_o (wbs_dat_o),
      .wbs_we_o  (wbs_we_o),
      .wbs_sel_o (wbs_sel_o),
      .wbs_stb_o (wbs_stb_o),
      .wbs_ack_i (wbs_ack_i),
      .wbs_err_i (wbs_err_i),
      .wbs_rty_i (wbs_rty_i),
      .wbs_cyc_o (wbs_cyc_o),
      .timeout_o (timeout_o)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic txn_t mk(
      input logic        we,
      input logic [31:0] adr,
      input logic [31:0] dat,
      input logic [3:0]  sel,
      input logic [31:0] sdat,
      input logic [1:0]  pri,
      input int k0, input int d0,
      input int k1, input int d1,
      input int k2, input int d2,
      input int k3, input int d3,
      input int eoc,
      input int enatt,
      input logic [31:0] erd
   );
      txn_t t;
      t.we = we;
      t.adr = adr;
      t.dat = dat;
      t.sel = sel;
      t.sdat = sdat;
      t.pri = pri;
      t.kind = '0;
      t.dly = '0;
      t.kind[0] = 2'(k0);
      t.dly[0] = 4'(d0);
      t.kind[1] = 2'(k1);
      t.dly[1] = 4'(d1);
      t.kind[2] = 2'(k2);
      t.dly[2] = 4'(d2);
      t.kind[3] = 2'(k3);
      t.dly[3] = 4'(d3);
      t.exp_oc = eoc;
      t.exp_natt = enatt;
      t.exp_rd = erd;
      return t;
   endfunction

   // Outcome of a transaction from the slave's script alone: each
   // attempt either answers within TO stall cycles or times out;
   // RTY is reissued until MR retries are used up.
   function automatic void model(
      input txn_t t,
      output int oc,
      output int natt,
      output logic [31:0] rd
   );
      int retries;
      retries = 0;
      oc = O_NONE;
      natt = 0;
      rd = '0;
      for (int k = 0; k < 6; k++) begin
         if (oc == O_NONE) begin
            natt = k + 1;
            if (int'(t.kind[k]) == K_NONE || int'(t.dly[k]) >= TO) begin
               oc = O_TO;
            end else if (int'(t.kind[k]) == K_ACK) begin
               oc = O_ACK;
               rd = t.sdat;
            end else if (int'(t.kind[k]) == K_ERR) begin
               oc = O_ERR;
            end else if (retries < MR) begin
               retries++;
            end else begin
               oc = O_RTY;
            end
         end
      end
   endfunction

   // Master issues t, slave follows t's per-attempt script.
   // Called and returns at a negedge.
   task automatic run_txn(
      input txn_t t,
      output int oc,
      output int natt,
      output logic [31:0] rd
   );
      int hi, gap, drv_c, rc, late_stb, pulses, k;
      bit prev_stb, stb;
      oc = O_NONE;
      natt = 0;
      rd = '0;
      hi = 0;
      gap = 0;
      drv_c = -10;
      rc = -1;
      late_stb = 0;
      pulses = 0;
      prev_stb = 1'b0;
      wbm_adr_i = t.adr;
      wbm_dat_i = t.dat;
      wbm_we_i = t.we;
      wbm_sel_i = t.sel;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      wbs_ack_i = 1'b0;
      wbs_err_i = 1'b0;
      wbs_rty_i = 1'b0;
      for (int c = 1; c <= 150; c++) begin
         if (rc < 0 || c <= rc + 4) begin
            @(negedge clk);
            stb = wbs_stb_o;
            wbs_ack_i = 1'b0;
            wbs_err_i = 1'b0;
            wbs_rty_i = 1'b0;
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
               pulses++;
               if (rc < 0) begin
                  rc = c;
                  rd = wbm_dat_o;
                  if (wbm_ack_o) oc = O_ACK;
                  else if (wbm_err_o) oc = timeout_o ? O_TO : O_ERR;
                  else oc = O_RTY;
                  if (oc == O_TO) begin
                     chk("timeout_stb_len", hi, TO);
                  end else begin
                     chk("resp_latency", c, drv_c + 1);
                     chk("timeout_quiet", int'(timeout_o), 0);
                  end
               end
            end
            if (rc >= 0 && c > rc) begin
               if (stb) late_stb++;
            end else if (stb) begin
               if (!prev_stb) begin
                  natt++;
                  hi = 0;
                  if (natt > 1) chk("backoff_gap", gap, 1);
                  chk("wbs_adr", wbs_adr_o, t.adr);
                  chk("wbs_dat", wbs_dat_o, t.dat);
                  chk("wbs_sel", int'(wbs_sel_o), int'(t.sel));
                  chk("wbs_we", int'(wbs_we_o), int'(t.we));
                  chk("wbs_cyc", int'(wbs_cyc_o), 1);
               end
               hi++;
               k = natt - 1;
               if (k < 6 && int'(t.kind[k]) != K_NONE
                   && hi == int'(t.dly[k]) + 1) begin
                  drv_c = c;
                  wbs_dat_i = t.sdat;
                  case (int'(t.kind[k]))
                     K_ACK: begin
                        wbs_ack_i = 1'b1;
                        wbs_err_i = t.pri[0];
                        wbs_rty_i = t.pri[1];
                     end
                     K_ERR: begin
                        wbs_err_i = 1'b1;
                        wbs_rty_i = t.pri[0];
                     end
                     default: wbs_rty_i = 1'b1;
                  endcase
               end
            end else begin
               if (prev_stb) gap = 0;
               gap++;
            end
            // A real master drops STB only after sampling the response.
            if (rc >= 0 && c == rc + 1) begin
               wbm_stb_i = 1'b0;
               wbm_cyc_i = 1'b0;
            end
            prev_stb = stb;
         end
      end
      if (rc < 0) chk("resp_seen", 0, 1);
      chk("resp_pulses", pulses, 1);
      chk("no_recapture", late_stb, 0);
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      wbs_ack_i = 1'b0;
      wbs_err_i = 1'b0;
      wbs_rty_i = 1'b0;
   endtask

   task automatic check_txn(input string name, input txn_t t);
      int oc, natt;
      logic [31:0] rd;
      run_txn(t, oc, natt, rd);
      chk({name, "_outcome"}, oc, t.exp_oc);
      chk({name, "_attempts"}, natt, t.exp_natt);
      if (t.exp_oc == O_ACK || t.exp_oc == O_ERR) begin
         chk({name, "_rdata"}, rd, t.exp_rd);
      end
   endtask

   task automatic watch_quiet(input string name, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (wbm_ack_o || wbm_err_o || wbm_rty_o || timeout_o || wbs_stb_o)
            seen++;
      end
      chk(name, seen, 0);
   endtask

   txn_t vec [10];

   initial begin
      txn_t t;
      int oc, natt, r;
      logic [31:0] rd;

      vec[0] = mk(1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 0,
                  K_ACK, 2, 0, 0, 0, 0, 0, 0, O_ACK, 1, 32'h0);
      vec[1] = mk(0, 32'h200, 32'h0, 4'hF, 32'h12345678, 0,
                  K_RTY, 0, K_RTY, 1, K_ACK, 0, 0, 0,
                  O_ACK, 3, 32'h12345678);
      vec[2] = mk(0, 32'h300, 32'h0, 4'h3, 32'h0, 0,
                  K_RTY, 0, K_RTY, 0, K_RTY, 2, K_RTY, 0,
                  O_RTY, 4, 32'h0);
      vec[3] = mk(1, 32'h400, 32'h55AA, 4'h1, 32'h0, 0,
                  K_NONE, 0, 0, 0, 0, 0, 0, 0, O_TO, 1, 32'h0);
      vec[4] = mk(0, 32'h404, 32'h0, 4'hF, 32'hA5A5A5A5, 0,
                  K_ACK, 7, 0, 0, 0, 0, 0, 0, O_ACK, 1, 32'hA5A5A5A5);
      vec[5] = mk(1, 32'h408, 32'h1, 4'h8, 32'h0, 0,
                  K_ERR, 0, 0, 0, 0, 0, 0, 0, O_ERR, 1, 32'h0);
      vec[6] = mk(0, 32'h40C, 32'h0, 4'hF, 32'h0, 0,
                  K_RTY, 3, K_NONE, 0, 0, 0, 0, 0, O_TO, 2, 32'h0);
      vec[7] = mk(0, 32'h500, 32'h0, 4'hF, 32'hCAFEF00D, 3,
                  K_ACK, 1, 0, 0, 0, 0, 0, 0, O_ACK, 1, 32'hCAFEF00D);
      vec[8] = mk(0, 32'h504, 32'h0, 4'hF, 32'h0, 1,
                  K_ERR, 0, 0, 0, 0, 0, 0, 0, O_ERR, 1, 32'h0);
      vec[9] = mk(0, 32'h508, 32'h0, 4'hF, 32'h77, 0,
                  K_ACK, 8, 0, 0, 0, 0, 0, 0, O_TO, 1, 32'h0);

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_cyc", int'(wbs_cyc_o), 0);
      chk("rst_stb", int'(wbs_stb_o), 0);
      chk("rst_ack", int'(wbm_ack_o), 0);
      chk("rst_err", int'(wbm_err_o), 0);
      chk("rst_rty", int'(wbm_rty_o), 0);
      chk("rst_timeout", int'(timeout_o), 0);
      chk("rst_adr", wbs_adr_o, 0);
      chk("rst_mdat", wbm_dat_o, 0);

      // Request held through reset; captured on the first cycle out.
      wbm_adr_i = 32'h40;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      @(negedge clk);
      chk("rst_holds_stb", int'(wbs_stb_o), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_capture_stb", int'(wbs_stb_o), 1);
      chk("first_capture_adr", wbs_adr_o, 32'h40);
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      @(negedge clk);
      chk("quick_abort_cyc", int'(wbs_cyc_o), 0);
      chk("quick_abort_stb", int'(wbs_stb_o), 0);
      watch_quiet("quick_abort_quiet", 4);

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         check_txn($sformatf("vec%0d", i), vec[i]);
      end

      // Bus lock: CYC without STB still reaches the slave.
      wbm_cyc_i = 1'b1;
      @(negedge clk);
      chk("lock_cyc", int'(wbs_cyc_o), 1);
      chk("lock_stb", int'(wbs_stb_o), 0);
      wbm_cyc_i = 1'b0;
      @(negedge clk);
      chk("unlock_cyc", int'(wbs_cyc_o), 0);

      // Master abort in ISSUE.
      wbm_adr_i = 32'h600;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_pre_stb", int'(wbs_stb_o), 1);
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      @(negedge clk);
      chk("abort_cyc", int'(wbs_cyc_o), 0);
      chk("abort_stb", int'(wbs_stb_o), 0);
      watch_quiet("abort_quiet", 10);
      check_txn("after_abort", vec[1]);

      // Reset while backing off after a slave RTY.
      wbm_adr_i = 32'h700;
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      @(negedge clk);
      chk("bo_pre_stb", int'(wbs_stb_o), 1);
      wbs_rty_i = 1'b1;
      @(negedge clk);
      wbs_rty_i = 1'b0;
      chk("bo_gap_stb", int'(wbs_stb_o), 0);
      wbm_stb_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("bo_rst_cyc", int'(wbs_cyc_o), 0);
      chk("bo_rst_stb", int'(wbs_stb_o), 0);
      rst_n = 1'b1;
      wbm_cyc_i = 1'b0;
      watch_quiet("bo_rst_quiet", 6);
      check_txn("after_reset", vec[0]);

      // Random scripts against the outcome model.
      for (int n = 0; n < 40; n++) begin
         t.we = 1'($urandom);
         t.adr = $urandom;
         t.dat = $urandom;
         t.sel = 4'($urandom);
         t.sdat = $urandom;
         t.pri = 2'($urandom);
         t.kind = '0;
         t.dly = '0;
         for (int k = 0; k < 6; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) t.kind[k] = 2'(K_NONE);
            else if (r <= 3) t.kind[k] = 2'(K_ACK);
            else if (r == 4) t.kind[k] = 2'(K_ERR);
            else t.kind[k] = 2'(K_RTY);
            t.dly[k] = 4'($urandom_range(0, 9));
         end
         model(t, oc, natt, rd);
         t.exp_oc = oc;
         t.exp_natt = natt;
         t.exp_rd = rd;
         check_txn($sformatf("rnd%0d", n), t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
